// File: rtl/ldpc_encoder_pkg.sv
// ldpc_enc_pkg: code dimensions, FSM state type and parity-generator rows
// shared by the LDPC encoder and its parity accumulator.
package ldpc_enc_pkg;

  localparam int K      = 8;             // information bits per codeword
  localparam int M      = 8;             // parity bits per codeword
  localparam int N      = K + M;         // codeword length
  localparam int CNT_W  = $clog2(N);     // in/out counter width
  localparam int IDX_W  = $clog2(K);     // info bit index width
  localparam int PIDX_W = $clog2(M);     // parity bit index width

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    EMIT_INFO = 2'd1,
    EMIT_PAR  = 2'd2
  } state_t;

  // Bit j of P_ROW[i] is the coefficient of u_i in p_j.
  localparam logic [M-1:0] P_ROW [0:K-1] = '{
    8'hD1, 8'hA3, 8'h47, 8'h8E,
    8'h1D, 8'h3A, 8'h74, 8'hE8
  };

endpackage

// File: rtl/ldpc_encoder_if.sv
// ldpc_encoder_if: bit-serial input and output handshakes of the encoder.
//   slave  : encoder side (accepts info bits, drives codeword bits)
//   master : source/sink side
interface ldpc_encoder_if;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_sop;
  logic out_last;
  logic busy;

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_sop, out_last, busy
  );

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_sop, out_last, busy
  );
endinterface

// File: rtl/ldpc_encoder_parity_accum.sv
// ldpc_parity_accum: M-bit GF(2) parity register. When enabled with a 1 data
// bit, XORs in the generator row selected by the info bit index.
//   clk, rst  : clock, async active-high reset
//   i_clr     : synchronous clear (end of codeword)
//   i_en      : info bit accepted this cycle
//   i_bit     : accepted info bit
//   i_idx     : index of the accepted info bit
//   o_parity  : accumulated parity p_0..p_{M-1}
module ldpc_parity_accum
  import ldpc_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  input  logic [IDX_W-1:0] i_idx,
  output logic [M-1:0]     o_parity
);

  logic [M-1:0] r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= '0;
    end else if (i_clr) begin
      r_parity <= '0;
    end else if (i_en && i_bit) begin
      r_parity <= r_parity ^ P_ROW[i_idx];
    end
  end

  assign o_parity = r_parity;

endmodule

// File: rtl/ldpc_encoder.sv
// ldpc_encoder: systematic serial LDPC encoder. Collects K info bits, then
// streams u_0..u_{K-1} followed by p_0..p_{M-1} with backpressure.
//   clk, rst : clock, async active-high reset
//   bus      : ldpc_encoder_if.slave (in_* handshake, out_* handshake, busy)
module ldpc_encoder
  import ldpc_enc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ldpc_encoder_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    r_out_cnt;
  logic [K-1:0]        r_info;
  logic [M-1:0]        w_parity;
  logic [PIDX_W-1:0]   w_par_idx;
  logic                w_in_acc;
  logic                w_out_acc;
  logic                w_word_done;

  assign w_in_acc    = bus.in_valid & bus.in_ready;
  assign w_out_acc   = bus.out_valid & bus.out_ready;
  assign w_word_done = w_out_acc && (r_out_cnt == CNT_W'(N-1));
  // Parity bits follow the info bits, so p_j sits at out_cnt = K + j.
  assign w_par_idx   = PIDX_W'(r_out_cnt - CNT_W'(K));
  assign bus.busy    = !((r_state == COLLECT) && (r_in_cnt == '0));

  ldpc_parity_accum u_parity_accum (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_word_done),
    .i_en     (w_in_acc),
    .i_bit    (bus.in_bit),
    .i_idx    (r_in_cnt[IDX_W-1:0]),
    .o_parity (w_parity)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    bus.out_sop   = 1'b0;
    bus.out_last  = 1'b0;
    case (r_state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (r_in_cnt == CNT_W'(K-1))) begin
          w_state_nxt = EMIT_INFO;
        end
      end
      EMIT_INFO: begin
        bus.out_valid = 1'b1;
        bus.out_bit   = r_info[r_out_cnt[IDX_W-1:0]];
        bus.out_sop   = (r_out_cnt == '0);
        if (bus.out_ready && (r_out_cnt == CNT_W'(K-1))) begin
          w_state_nxt = EMIT_PAR;
        end
      end
      EMIT_PAR: begin
        bus.out_valid = 1'b1;
        bus.out_bit   = w_parity[w_par_idx];
        bus.out_last  = (r_out_cnt == CNT_W'(N-1));
        if (bus.out_ready && (r_out_cnt == CNT_W'(N-1))) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_info    <= '0;
    end else begin
      if (w_in_acc) begin
        r_info[r_in_cnt[IDX_W-1:0]] <= bus.in_bit;
        r_in_cnt <= (r_in_cnt == CNT_W'(K-1)) ? '0 : r_in_cnt + CNT_W'(1);
      end
      if (w_word_done) begin
        r_out_cnt <= '0;
        r_info    <= '0;
      end else if (w_out_acc) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/ldpc_encoder.md
# ldpc_encoder

Systematic serial LDPC encoder producing the codewords that the LDPC decoder consumes; it is the transmit-side counterpart of the check-node/φ-LUT decoding path. It accepts K information bits one per handshake, accumulates M parity bits over GF(2) using the fixed parity-generator rows, then streams the N = K+M codeword bits out with backpressure. It sits between the test-pattern/data source and the channel model (BPSK mapping + noise) in the loopback bench and FPGA demo.

## Interface
- K, 8, information bits per codeword; must equal `ldpc_enc_pkg::K`.
- M, 8, parity bits per codeword; must equal `ldpc_enc_pkg::M`.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  source has an information bit.
- in_ready  out  1  encoder accepts a bit this cycle.
- in_bit  in  1  information bit u_i; the first accepted bit is u_0.
- out_valid  out  1  codeword bit available.
- out_ready  in  1  sink accepts the bit this cycle.
- out_bit  out  1  codeword bit c_j.
- out_sop  out  1  high with c_0.
- out_last  out  1  high with c_{N-1}.
- busy  out  1  high whenever state is not COLLECT with in_cnt = 0.

## Operation
- States:
  - COLLECT: in_ready = 1, out_valid = 0.
  - EMIT_INFO: c_0..c_{K-1} = u_0..u_{K-1}.
  - EMIT_PAR: c_{K+j} = p_j, j = 0..M-1, parity LSB first.
- Input handshake: in_valid & in_ready.
  - On accept: info_reg[in_cnt] ← in_bit.
  - If in_bit = 1: parity ← parity XOR P_ROW[in_cnt]; if in_bit = 0, parity is unchanged.
  - in_cnt increments.
  - On the K-th accept: in_cnt wraps to 0 and state → EMIT_INFO.
- Output handshake: out_valid & out_ready advances out_cnt (0..N-1).
  - At out_cnt = K-1 accept: state → EMIT_PAR.
  - At out_cnt = N-1 accept: state → COLLECT, and parity, out_cnt and info_reg clear.
- out_bit, out_sop and out_last are combinational from the registered state, out_cnt, info_reg and parity.
  - They hold stable while out_valid & !out_ready.
- No overlap: in_ready = 0 during EMIT_INFO and EMIT_PAR. Input arriving then is held off, not dropped.
- All GF(2) arithmetic is M-bit XOR. Counters are ⌈log2(N)⌉ bits; there is no arithmetic overflow.
- Reset at any time (mid-collect or mid-emit):
  - The partial word is discarded, all registers clear, and the state returns to COLLECT.
  - The next accepted bit is u_0.

## Timing
- Reset values:
  - in_ready = 1 (COLLECT, enabled once reset deasserts).
  - out_valid = 0, out_bit = 0, out_sop = 0, out_last = 0, busy = 0.
- If the K-th input is accepted at edge t, out_valid = 1 with c_0 and out_sop in the cycle after t.
- The encoder emits one bit per cycle when out_ready is held high.
- Minimum period is K + N = 24 cycles per codeword.
- If the last output is accepted at edge t, in_ready = 1 in the cycle after t.
- in_valid may toggle freely. Only cycles with a handshake affect state.

## Structure
- Package `ldpc_enc_pkg`:
  - K = 8, M = 8, N = 16.
  - State enum {COLLECT, EMIT_INFO, EMIT_PAR}.
  - `P_ROW[0:K-1]` (M-bit each), where bit j of P_ROW[i] is the coefficient of u_i in p_j:
    - P_ROW[0..3] = 8'hD1, 8'hA3, 8'h47, 8'h8E
    - P_ROW[4..7] = 8'h1D, 8'h3A, 8'h74, 8'hE8
- Sub-module `ldpc_parity_accum`:
  - Purpose: M-bit register with clear, enable, data bit and row index; holds the XOR-accumulate logic.
  - Ports: clk, rst, clr, en, bit, idx, parity.
- The top level holds the FSM, the counters and info_reg.

## Test plan
- All-zero word: u = 0x00 → 16 bits all 0; out_sop on c_0, out_last on c_15; latency exactly 1 cycle after the 8th accept.
- Single bit: u_0 = 1, rest 0 → codeword info 0x01, parity 0xD1, so c_8..c_15 = 1,0,0,0,1,0,1,1.
- Two bits: u_0 = u_1 = 1 → parity 0x72. All ones: u = 0xFF → parity 0x00.
- Backpressure: random out_ready at 30% duty → out_bit, out_sop and out_last stable while stalled; identical bit sequence to the unstalled run; in_ready = 0 throughout emit.
- Reset mid-emit:
  - Stimulus: assert rst asynchronously after c_5.
  - Response: out_valid drops immediately, in_ready = 1 after release.
  - Then u = 0x01 → parity 0xD1, with no residue from the aborted word.
- Back-to-back: three random words with in_valid held high → each parity matches the software XOR model; exactly 24 cycles per word with out_ready = 1.
